// File: rtl/wb_hazard_scoreboard.sv
// In-order queue of in-flight GPR/CSR writers with combinational RAW-hazard lookup.
// Push/pop take effect on the next edge; hazards see only registered occupancy.
module wb_hazard_scoreboard #(
  parameter int DEPTH          = 4,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [RF_ADDR_WIDTH-1:0]  issue_rd,
  input  logic                      issue_csr_we,
  input  logic [CSR_ADDR_WIDTH-1:0] issue_csr_waddr,
  input  logic                      commit_valid,
  input  logic [RF_ADDR_WIDTH-1:0]  commit_rd,
  input  logic                      commit_csr_we,
  input  logic                      flush,
  input  logic [RF_ADDR_WIDTH-1:0]  rs1,
  input  logic [RF_ADDR_WIDTH-1:0]  rs2,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr,
  input  logic                      csr_re,
  output logic                      rs1_hazard,
  output logic                      rs2_hazard,
  output logic                      csr_hazard,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic                      gpr_v_q [DEPTH];
  logic [RF_ADDR_WIDTH-1:0]  rd_q    [DEPTH];
  logic                      csr_v_q [DEPTH];
  logic [CSR_ADDR_WIDTH-1:0] csr_a_q [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic push, pop, mismatch;
  logic [DEPTH-1:0] occ;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign issue_ready = !full;
  assign count       = count_q;
  assign err         = err_q;

  // Full blocks issue even when a commit frees a slot this cycle.
  assign push = issue_valid && !full;
  assign pop  = commit_valid && !empty;

  assign mismatch = (gpr_v_q[head_q] ? (commit_rd != rd_q[head_q])
                                     : (commit_rd != '0))
                  || (commit_csr_we != csr_v_q[head_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        gpr_v_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        csr_v_q[i] <= 1'b0;
        csr_a_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        gpr_v_q[tail_q] <= (issue_rd != '0);
        rd_q[tail_q]    <= issue_rd;
        csr_v_q[tail_q] <= issue_csr_we;
        csr_a_q[tail_q] <= issue_csr_waddr;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      if (commit_valid && (empty || mismatch)) err_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  always_comb begin
    rs1_hazard = 1'b0;
    rs2_hazard = 1'b0;
    csr_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && gpr_v_q[i] && (rd_q[i] == rs1) && (rs1 != '0)) rs1_hazard = 1'b1;
      if (occ[i] && gpr_v_q[i] && (rd_q[i] == rs2) && (rs2 != '0)) rs2_hazard = 1'b1;
      if (occ[i] && csr_v_q[i] && (csr_a_q[i] == csr_raddr) && csr_re) csr_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Bench for wb_hazard_scoreboard: queue-based reference of in-flight writers.
module tb_wb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_ready, issue_csr_we;
  logic [4:0]  issue_rd, commit_rd, rs1, rs2;
  logic [11:0] issue_csr_waddr, csr_raddr;
  logic        commit_valid, commit_csr_we, flush, csr_re;
  logic        rs1_hazard, rs2_hazard, csr_hazard, empty, full, err;
  logic [2:0]  count;

  typedef struct {
    bit         gpr_v;
    logic [4:0] rd;
    bit         csr_v;
    logic [11:0] csr;
  } ent_t;

  ent_t mq[$];
  bit   m_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_hazard_scoreboard #(.DEPTH(4), .RF_ADDR_WIDTH(5), .CSR_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_csr_we(issue_csr_we), .issue_csr_waddr(issue_csr_waddr),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_csr_we(commit_csr_we),
    .flush(flush), .rs1(rs1), .rs2(rs2), .csr_raddr(csr_raddr), .csr_re(csr_re),
    .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard), .csr_hazard(csr_hazard),
    .count(count), .empty(empty), .full(full), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit gpr_haz(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].gpr_v && mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit csr_haz(input logic [11:0] a, input bit re);
    if (!re) return 1'b0;
    foreach (mq[i]) if (mq[i].csr_v && mq[i].csr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    rst = 0; issue_valid = 0; issue_rd = 0; issue_csr_we = 0; issue_csr_waddr = 0;
    commit_valid = 0; commit_rd = 0; commit_csr_we = 0; flush = 0;
  endtask

  // One clock: drive, update reference on the edge, then compare registered state.
  task automatic step(input bit r, input bit fl,
                      input bit iv, input logic [4:0] ird, input bit icwe, input logic [11:0] ica,
                      input bit cv, input logic [4:0] crd, input bit ccwe);
    bit do_push, do_pop;
    ent_t h;
    rst = r; flush = fl;
    issue_valid = iv; issue_rd = ird; issue_csr_we = icwe; issue_csr_waddr = ica;
    commit_valid = cv; commit_rd = crd; commit_csr_we = ccwe;
    @(posedge clk);
    do_push = iv && (mq.size() < 4);
    do_pop  = cv && (mq.size() > 0);
    if (r) begin
      mq.delete(); m_err = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (cv && !do_pop) m_err = 1;
      if (do_pop) begin
        h = mq.pop_front();
        if ((h.gpr_v ? (crd != h.rd) : (crd != 0)) || (ccwe != h.csr_v)) m_err = 1;
      end
      if (do_push) mq.push_back('{gpr_v: (ird != 0), rd: ird, csr_v: icwe, csr: ica});
    end
    @(negedge clk);
    idle_inputs();
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("empty", 32'(empty), 32'(mq.size() == 0));
    check_eq("full", 32'(full), 32'(mq.size() == 4));
    check_eq("issue_ready", 32'(issue_ready), 32'(mq.size() != 4));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic push(input logic [4:0] rd, input bit cwe, input logic [11:0] ca);
    step(0, 0, 1, rd, cwe, ca, 0, 0, 0);
  endtask

  task automatic commit(input logic [4:0] rd, input bit cwe);
    step(0, 0, 0, 0, 0, 0, 1, rd, cwe);
  endtask

  task automatic probe(input logic [4:0] a, input logic [4:0] b, input logic [11:0] ca, input bit re);
    rs1 = a; rs2 = b; csr_raddr = ca; csr_re = re;
    #1;
    check_eq("rs1_hazard", 32'(rs1_hazard), 32'(gpr_haz(a)));
    check_eq("rs2_hazard", 32'(rs2_hazard), 32'(gpr_haz(b)));
    check_eq("csr_hazard", 32'(csr_hazard), 32'(csr_haz(ca, re)));
  endtask

  initial begin
    ent_t h;
    idle_inputs();
    rs1 = 0; rs2 = 0; csr_raddr = 0; csr_re = 0; m_err = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    probe(5, 1, 12'h300, 1);
    check_eq("reset_count_const", 32'(count), 32'd0);

    // Basic GPR + CSR writers
    push(5, 0, 0);
    push(0, 1, 12'h300);
    check_eq("basic_count", 32'(count), 32'd2);
    probe(5, 0, 12'h300, 1);
    check_eq("basic_rs1_hit", 32'(rs1_hazard), 32'd1);
    check_eq("basic_csr_hit", 32'(csr_hazard), 32'd1);
    probe(6, 5, 12'h301, 1);
    probe(5, 5, 12'h300, 0);
    commit(5, 0);
    probe(5, 0, 12'h300, 1);
    commit(0, 1);
    probe(5, 0, 12'h300, 1);
    check_eq("basic_err", 32'(err), 32'd0);

    // Fill to DEPTH, blocked issue, commit+issue while full
    for (int i = 1; i <= 4; i++) push(5'(i), 0, 0);
    check_eq("full_flag", 32'(full), 32'd1);
    push(9, 0, 0);
    probe(9, 4, 0, 0);
    step(0, 0, 1, 9, 0, 0, 1, 1, 0);
    check_eq("full_commit_issue_count", 32'(count), 32'd3);
    probe(9, 1, 0, 0);
    push(9, 0, 0);
    check_eq("refill_count", 32'(count), 32'd4);
    probe(9, 2, 0, 0);
    check_eq("refill_rs1_hit", 32'(rs1_hazard), 32'd1);
    foreach (mq[i]) ;
    while (mq.size() > 0) begin
      h = mq[0];
      commit(h.rd, h.csr_v);
    end

    // Wrap-around with alternating push/commit
    for (int i = 0; i < 10; i++) begin
      push(5'(i + 1), 0, 0);
      probe(5'(i + 1), 5'(i + 2), 0, 0);
      commit(5'(i + 1), 0);
      probe(5'(i + 1), 0, 0, 0);
    end
    check_eq("wrap_err", 32'(err), 32'd0);

    // Commit mismatch is sticky
    push(7, 0, 0);
    commit(8, 0);
    check_eq("mismatch_err", 32'(err), 32'd1);
    push(2, 0, 0);
    commit(2, 0);
    push(0, 1, 12'h305);
    commit(0, 0);

    // Underflow after fresh reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    commit(0, 0);
    check_eq("underflow_err", 32'(err), 32'd1);

    // Flush drops concurrent issue/commit, err untouched
    push(3, 0, 0);
    push(4, 1, 12'h341);
    step(0, 1, 1, 6, 0, 0, 1, 3, 0);
    probe(3, 4, 12'h341, 1);
    probe(6, 0, 0, 0);
    check_eq("flush_err_kept", 32'(err), 32'd1);

    // Reset mid-operation
    push(10, 0, 0);
    push(11, 1, 12'h7c0);
    push(12, 0, 0);
    step(1, 0, 1, 13, 0, 0, 1, 10, 0);
    probe(10, 12, 12'h7c0, 1);

    // Random legal/illegal traffic
    for (int n = 0; n < 200; n++) begin
      logic [4:0] rd, crd;
      bit cv, ccwe, fl, cwe;
      rd   = 5'($urandom_range(0, 7));
      cwe  = ($urandom_range(0, 3) == 0);
      cv   = ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 19) == 0);
      crd  = (mq.size() > 0) ? mq[0].rd : 5'd0;
      ccwe = (mq.size() > 0) ? mq[0].csr_v : 1'b0;
      if ($urandom_range(0, 29) == 0) crd = crd + 5'd1;
      step(($urandom_range(0, 49) == 0), fl, ($urandom_range(0, 2) != 0), rd, cwe,
           12'(12'h300 + $urandom_range(0, 3)), cv, crd, ccwe);
      probe(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            12'(12'h300 + $urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_hazard_scoreboard.md
# wb_hazard_scoreboard

Parametrised in-flight writer tracker for the SCHOLAR RISC-V pipeline controller. Generalises the single-entry WB->CTRL commit payload to a DEPTH-entry in-order queue of pending GPR/CSR destinations. Entries are pushed at issue and retired at write-back. Combinational RAW-hazard flags are provided for two GPR sources and one CSR source, plus flush, occupancy and a sticky commit-mismatch error.

## Interface
- DEPTH, 4, max in-flight writers; power of two, >= 2
- RF_ADDR_WIDTH, 5, GPR index width
- CSR_ADDR_WIDTH, 12, CSR address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- issue_valid  in  1  push request
- issue_ready  out  1  queue can accept; = !full
- issue_rd  in  RF_ADDR_WIDTH  destination GPR; x0 = no GPR write
- issue_csr_we  in  1  instruction writes a CSR
- issue_csr_waddr  in  CSR_ADDR_WIDTH  destination CSR
- commit_valid  in  1  WB retires oldest entry
- commit_rd  in  RF_ADDR_WIDTH  rd reported by WB, checked against head
- commit_csr_we  in  1  CSR write flag reported by WB, checked against head
- flush  in  1  discard all entries
- rs1, rs2  in  RF_ADDR_WIDTH  source GPRs to check
- csr_raddr  in  CSR_ADDR_WIDTH  source CSR to check
- csr_re  in  1  csr_raddr is meaningful
- rs1_hazard, rs2_hazard, csr_hazard  out  1  pending writer matches source
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- err  out  1  sticky commit mismatch / underflow

## Operation
- Storage: circular buffer of DEPTH entries {gpr_v, rd, csr_v, csr_waddr}. gpr_v = (issue_rd != 0). csr_v = issue_csr_we. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: when issue_valid && issue_ready, write the entry at tail and advance tail. An issue_valid while full is ignored; the upstream must hold it.
- Pop: when commit_valid && !empty, retire the head and advance head.
- Commit check:
  - err is set when a pop has head.gpr_v and commit_rd != head.rd.
  - err is set when a pop has head.gpr_v == 0 and commit_rd != 0.
  - err is set when commit_csr_we != head.csr_v.
  - err is set when commit_valid arrives while empty (underflow). No pointer moves in that case.
- Simultaneous push+pop: both occur and count is unchanged. When full, issue_ready is low even with a concurrent commit; there is no pass-through.
- Flush: head = tail = 0 and count = 0. A concurrent issue and commit are dropped, with no commit check and no err update. err keeps its value.
- Hazards, combinational over occupied entries only (valid-mask derived from head/count):
  - rsN_hazard = (rsN != 0) && any entry with gpr_v && rd == rsN.
  - csr_hazard = csr_re && any entry with csr_v && csr_waddr == csr_raddr.
- Entries being pushed or popped in the current cycle are judged on the pre-edge state. An entry popped this cycle still flags a hazard this cycle. An entry pushed this cycle does not flag until the next cycle.
- err clears only on rst.

## Timing
- Reset, synchronous: after the first rising edge with rst=1:
  - head=tail=0, count=0, empty=1, full=0, issue_ready=1, err=0, all hazard outputs 0.
  - rst overrides flush, issue and commit.
- Push latency: 1 cycle. An entry written at edge N is visible in count and the hazards after edge N.
- Pop latency: 1 cycle. The hazard is cleared after the commit edge.
- count, empty, full and issue_ready are registered-state derived and carry no combinational path from the issue/commit inputs.
- Hazard outputs are combinational from rs1/rs2/csr_raddr/csr_re and registered state. They have no path from the issue_*/commit_* inputs.
- Wrap-around: pointers increment modulo DEPTH. A full buffer has head == tail with count == DEPTH.

## Test plan
- Reset then push {rd=5}, {rd=0, csr_we=1, csr=0x300}. Expected: count=2. rs1=5 gives rs1_hazard=1. rs2=0 gives 0. csr_re=1, csr_raddr=0x300 gives csr_hazard=1. Commit rd=5 then rd=0/csr_we=1 gives empty=1, all hazards 0, err=0.
- DEPTH=4: push rd=1..4. Expected: full=1, issue_ready=0. A 5th issue_valid with rd=9 is ignored, so rs1=9 gives no hazard. Commit+issue rd=9 in the same cycle gives count stays 3, then 4 next cycle with rs1=9 hazard.
- Wrap: run 10 push/commit pairs with rd=i+1. Expected: each commit matches, err=0, count oscillates 0/1, pointers wrap cleanly.
- Mismatch: push rd=7, commit rd=8. Expected: err=1 next cycle and stays 1 after subsequent correct traffic. Commit on empty with a fresh rst sets err=1 and count stays 0.
- Flush: push rd=3, rd=4, then flush with concurrent issue rd=6 and commit rd=3. Expected: count=0, no hazard on 3/4/6, err unchanged.
- Reset mid-operation: with 3 entries and err=1, assert rst for one edge. Expected: count=0, empty=1, err=0, hazards 0.
